// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, word-length codes and the
// framing helpers used by both the transmit and receive engines.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned UART_DATA_W        = 8;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Line-control fields captured when a byte is loaded, plus its parity bit.
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       parity;
  } tx_frame_t;

  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] wls);
    return 8'hFF >> (2'd3 - wls);
  endfunction

  // Stick parity overrides; otherwise even parity when eps=1, odd when eps=0.
  function automatic logic uart_parity(
    input logic [7:0] data,
    input logic [1:0] wls,
    input logic       eps,
    input logic       sticky
  );
    if (sticky) begin
      return ~eps;
    end
    return (^(data & data_mask(wls))) ^ ~eps;
  endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// UART transmit serialiser: pops bytes from a show-ahead TX FIFO and frames
// them as start / 5-8 data bits LSB first / optional parity / 1, 1.5 or 2 stop.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int unsigned DATA_W     = UART_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              baud_pulse_i,
  input  logic [1:0]        wls_i,
  input  logic              stb_i,
  input  logic              pen_i,
  input  logic              eps_i,
  input  logic              sticky_par_i,
  input  logic              set_break_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_dout_i,
  output logic              fifo_pop_o,
  output logic              tx_o,
  output logic              temt_o,
  output logic              busy_o
);

  localparam int unsigned TICK_W = $clog2(2 * OVERSAMPLE);

  localparam logic [TICK_W-1:0] BIT_LAST      = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_1P5_LAST = TICK_W'((OVERSAMPLE * 3) / 2 - 1);
  localparam logic [TICK_W-1:0] STOP_2_LAST   = TICK_W'(2 * OVERSAMPLE - 1);

  tx_state_e         state_q;
  tx_frame_t         frame_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tx_q;
  logic              pop_q;
  logic              busy_q;

  logic [7:0]        shift_d;
  logic [2:0]        bit_cnt_d;
  logic [TICK_W-1:0] tick_cnt_d;

  logic [7:0]        load_data;
  tx_frame_t         load_frame;
  logic              load_go;
  logic [2:0]        bit_last_idx;
  logic [TICK_W-1:0] stop_last;
  logic [TICK_W-1:0] tick_last;
  logic              tick_end;

  always_comb begin
    load_data         = 8'(fifo_dout_i) & data_mask(wls_i);
    load_frame.wls    = wls_i;
    load_frame.stb    = stb_i;
    load_frame.pen    = pen_i;
    load_frame.parity = uart_parity(load_data, wls_i, eps_i, sticky_par_i);
    load_go           = en_i && !fifo_empty_i;
  end

  always_comb begin
    shift_d      = shift_q >> 1;
    bit_cnt_d    = bit_cnt_q + 3'd1;
    tick_cnt_d   = tick_cnt_q + 1'b1;
    bit_last_idx = 3'(data_bits(frame_q.wls) - 4'd1);

    // Only the 5-bit word turns the long stop into one and a half bits.
    stop_last = BIT_LAST;
    if (frame_q.stb) begin
      stop_last = (frame_q.wls == WLS_5) ? STOP_1P5_LAST : STOP_2_LAST;
    end

    tick_last = (state_q == TX_STOP) ? stop_last : BIT_LAST;
    tick_end  = baud_pulse_i && (tick_cnt_q == tick_last);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= TX_IDLE;
      frame_q    <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tick_cnt_q <= '0;
      tx_q       <= 1'b1;
      pop_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pop_q <= 1'b0;

      case (state_q)
        TX_IDLE: begin
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (load_go) begin
            pop_q   <= 1'b1;
            frame_q <= load_frame;
            shift_q <= load_data;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= TX_START;
          end
        end

        TX_START: begin
          if (tick_end) begin
            tick_cnt_q <= '0;
            tx_q       <= shift_q[0];
            state_q    <= TX_DATA;
          end else if (baud_pulse_i) begin
            tick_cnt_q <= tick_cnt_d;
          end
        end

        TX_DATA: begin
          if (tick_end) begin
            tick_cnt_q <= '0;
            if (bit_cnt_q == bit_last_idx) begin
              if (frame_q.pen) begin
                tx_q    <= frame_q.parity;
                state_q <= TX_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= TX_STOP;
              end
            end else begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_d;
              tx_q      <= shift_d[0];
            end
          end else if (baud_pulse_i) begin
            tick_cnt_q <= tick_cnt_d;
          end
        end

        TX_PARITY: begin
          if (tick_end) begin
            tick_cnt_q <= '0;
            tx_q       <= 1'b1;
            state_q    <= TX_STOP;
          end else if (baud_pulse_i) begin
            tick_cnt_q <= tick_cnt_d;
          end
        end

        TX_STOP: begin
          if (tick_end) begin
            tick_cnt_q <= '0;
            busy_q     <= 1'b0;
            state_q    <= TX_IDLE;
          end else if (baud_pulse_i) begin
            tick_cnt_q <= tick_cnt_d;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // Break overrides the line without disturbing the frame underneath.
  assign tx_o       = tx_q & ~set_break_i;
  assign fifo_pop_o = pop_q;
  assign busy_o     = busy_q;
  assign temt_o     = ~busy_q & fifo_empty_i;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a show-ahead FIFO model feeds the engine and a
// tick-level reference waveform built from the framing rules checks every frame.
module tb_uart_tx_engine;

  localparam int OS       = 16;
  localparam int BAUD_DIV = 3;
  localparam int WAIT_LIM = 3000;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       en = 1'b0;
  logic       baud = 1'b0;
  logic [1:0] wls = 2'b11;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sticky = 1'b0;
  logic       brk = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_pop;
  logic       tx;
  logic       temt;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sent_exp[$];
  logic       exp_wave[$];
  logic       samp_q[$];
  logic       brk_q[$];
  logic       last_samp[$];
  int         last_ticks = 0;
  int         frames_done = 0;
  int         pop_cnt = 0;

  uart_tx_engine #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .en_i         (en),
    .baud_pulse_i (baud),
    .wls_i        (wls),
    .stb_i        (stb),
    .pen_i        (pen),
    .eps_i        (eps),
    .sticky_par_i (sticky),
    .set_break_i  (brk),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_pop_o   (fifo_pop),
    .tx_o         (tx),
    .temt_o       (temt),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endfunction

  // Expected line level for every baud tick of one frame.
  function automatic void build_wave(input logic [7:0] d, input logic [1:0] w, input logic s,
                                     input logic p, input logic e, input logic st);
    int nbits;
    int ones;
    int stop_ticks;
    logic par;
    nbits = 5 + int'(w);
    ones  = 0;
    exp_wave.delete();
    repeat (OS) exp_wave.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      repeat (OS) exp_wave.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p) begin
      if (st) par = !e;
      else    par = e ? (ones % 2 == 1) : (ones % 2 == 0);
      repeat (OS) exp_wave.push_back(par);
    end
    if (!s)         stop_ticks = OS;
    else if (w == 0) stop_ticks = OS * 3 / 2;
    else            stop_ticks = 2 * OS;
    repeat (stop_ticks) exp_wave.push_back(1'b1);
  endfunction

  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      baud = (c == 0);
      c = (c + 1) % BAUD_DIV;
    end
  end

  // Show-ahead FIFO: pop strobe sampled mid-cycle, applied just after the edge.
  initial begin
    logic pop_now;
    forever begin
      @(negedge clk);
      pop_now = fifo_pop && rst_ni;
      if (pop_now) check("pop_when_nonempty", fifo_empty, 1'b0);
      @(posedge clk);
      #1;
      if (pop_now) begin
        pop_cnt++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_refresh();
      end
    end
  end

  // Frame monitor: records tx on every baud tick while busy.
  initial begin
    logic       prev_busy = 1'b0;
    logic       active = 1'b0;
    logic       gap_armed = 1'b0;
    int         idle_cnt = 0;
    int         mism;
    logic       lvl;
    logic [7:0] d;
    logic [1:0] c_wls;
    logic       c_stb, c_pen, c_eps, c_sticky;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        active = 1'b0; prev_busy = 1'b0; gap_armed = 1'b0;
        samp_q.delete(); brk_q.delete();
        continue;
      end
      if (busy && !prev_busy) begin
        if (gap_armed) check("idle_gap", idle_cnt, 1);
        gap_armed = 1'b0;
        active = 1'b1;
        samp_q.delete(); brk_q.delete();
        c_wls = wls; c_stb = stb; c_pen = pen; c_eps = eps; c_sticky = sticky;
      end
      if (busy && baud) begin
        samp_q.push_back(tx);
        brk_q.push_back(brk);
      end
      if (!busy && prev_busy && active) begin
        if (sent_exp.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          d = sent_exp.pop_front();
          build_wave(d, c_wls, c_stb, c_pen, c_eps, c_sticky);
          check("frame_ticks", samp_q.size(), exp_wave.size());
          mism = 0;
          for (int i = 0; i < samp_q.size() && i < exp_wave.size(); i++) begin
            lvl = brk_q[i] ? 1'b0 : exp_wave[i];
            if (samp_q[i] !== lvl) mism++;
          end
          check("frame_wave", mism, 0);
          $display("frame %0d: data=%02h wls=%0d stb=%0b pen=%0b eps=%0b stick=%0b ticks=%0d",
                   frames_done, d, c_wls, c_stb, c_pen, c_eps, c_sticky, samp_q.size());
        end
        last_samp  = samp_q;
        last_ticks = samp_q.size();
        frames_done++;
        active    = 1'b0;
        idle_cnt  = 0;
        gap_armed = en && !fifo_empty;
      end
      if (!busy) idle_cnt++;
      prev_busy = busy;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    sent_exp.push_back(b);
    fifo_refresh();
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic s, input logic p,
                         input logic e, input logic st);
    wls = w; stb = s; pen = p; eps = e; sticky = st;
  endtask

  task automatic wait_rise();
    int k = 0;
    while (!busy && k < WAIT_LIM) begin tick_clk(1); k++; end
    if (!busy) check("timeout_busy_rise", 0, 1);
  endtask

  task automatic wait_fall();
    int k = 0;
    while (busy && k < WAIT_LIM) begin tick_clk(1); k++; end
    if (busy) check("timeout_busy_fall", 1, 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while ((busy || fifo_q.size() != 0) && k < 20 * WAIT_LIM) begin tick_clk(1); k++; end
    if (busy || fifo_q.size() != 0) check("timeout_drain", 1, 0);
    tick_clk(2);
  endtask

  initial begin
    bit [0:9] seq_8n1;
    int f0, p0;
    tick_clk(3);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_pop", fifo_pop, 1'b0);
    check("reset_temt", temt, 1'b1);
    rst_ni = 1'b1;
    tick_clk(4);

    // 8N1 0xA5
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    f0 = frames_done; p0 = pop_cnt;
    push(8'hA5);
    en = 1'b1;
    wait_done();
    check("8n1_frames", frames_done - f0, 1);
    check("8n1_pops", pop_cnt - p0, 1);
    check("8n1_ticks", last_ticks, 160);
    check("8n1_temt", temt, 1'b1);
    check("8n1_tx_idle", tx, 1'b1);
    seq_8n1 = 10'b0101001011;
    for (int i = 0; i < 10; i++)
      check($sformatf("8n1_bit%0d", i), last_samp[i * OS + OS / 2], seq_8n1[i]);

    // 7E2 0xFF
    set_cfg(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    push(8'hFF);
    wait_done();
    check("7e2_ticks", last_ticks, 176);
    check("7e2_parity", last_samp[8 * OS + OS / 2], 1'b1);

    // 5-bit, odd parity, 1.5 stop
    set_cfg(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    push(8'h1F);
    wait_done();
    check("5o15_ticks", last_ticks, 136);
    check("5o15_parity", last_samp[6 * OS + OS / 2], 1'b0);

    // Stick parity with eps=0 gives a 1 regardless of data
    set_cfg(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    push(8'h00);
    wait_done();
    check("stick_par_00", last_samp[9 * OS + OS / 2], 1'b1);
    push(8'hFF);
    wait_done();
    check("stick_par_ff", last_samp[9 * OS + OS / 2], 1'b1);

    // Break during DATA
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h3C);
    wait_rise();
    tick_clk(100);
    brk = 1'b1;
    #1;
    check("break_tx_low", tx, 1'b0);
    check("break_busy", busy, 1'b1);
    check("break_temt", temt, 1'b0);
    tick_clk(60);
    brk = 1'b0;
    wait_done();
    check("break_ticks", last_ticks, 160);

    // Streaming with mid-frame LCR changes and an en=0 pause
    f0 = frames_done; p0 = pop_cnt;
    en = 1'b0;
    for (int i = 0; i < 20; i++) push(8'($urandom_range(0, 255)));
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_rise();
      tick_clk(20);
      if (k == 9) en = 1'b0;
      else set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_fall();
      if (k == 9) begin
        tick_clk(300);
        check("en_off_pops", pop_cnt - p0, 10);
        check("en_off_busy", busy, 1'b0);
        check("en_off_fifo_left", fifo_q.size(), 10);
        en = 1'b1;
      end
    end
    wait_done();
    check("stream_pops", pop_cnt - p0, 20);
    check("stream_frames", frames_done - f0, 20);

    // Reset mid-DATA
    set_cfg(2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h5A);
    push(8'hC3);
    wait_rise();
    tick_clk(80);
    p0 = pop_cnt;
    rst_ni = 1'b0;
    en = 1'b0;
    #1;
    check("midreset_tx", tx, 1'b1);
    check("midreset_busy", busy, 1'b0);
    check("midreset_pop", fifo_pop, 1'b0);
    tick_clk(5);
    rst_ni = 1'b1;
    tick_clk(100);
    check("post_reset_no_pop", pop_cnt - p0, 0);
    check("post_reset_tx", tx, 1'b1);
    sent_exp = fifo_q;
    f0 = frames_done;
    en = 1'b1;
    wait_done();
    check("post_reset_frames", frames_done - f0, 1);
    check("final_temt", temt, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
